// File: rtl/filter_pkg.sv
// filter_pkg: definitions shared by the convolution tap accumulator.
//   TAPS_DEFAULT : taps per window (a 5x5 kernel)
//   IDX_W        : width of the tap index carried alongside each product
//   state_t      : accumulator FSM states (ACCUM, HOLD)
//   clamp_signed : clamps a 64-bit signed value to a signed out_w-bit range
package filter_pkg;

    localparam int TAPS_DEFAULT = 25;
    localparam int IDX_W        = 5;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Result stays 64 bits wide; the caller keeps the low out_w bits, which
    // hold the clamped value exactly because it is inside the out_w range.
    function automatic logic signed [63:0] clamp_signed(
        input logic signed [63:0] v,
        input int                 out_w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/tap_index_counter.sv
// tap_index_counter: modulo-TAPS index counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_en       : advance by one (wraps from TAPS-1 back to 0)
//   i_clr      : synchronous clear, has priority over i_en
//   o_idx      : current index
//   o_wrap     : one-cycle pulse when the index advances from TAPS-1
module tap_index_counter #(
    parameter int TAPS = 25,
    parameter int W    = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_idx,
    output logic         o_wrap
);

    localparam logic [W-1:0] LAST_IDX = W'(TAPS - 1);

    logic [W-1:0] r_idx;
    logic         w_at_last;

    assign w_at_last = (r_idx == LAST_IDX);
    assign o_wrap    = i_en & w_at_last;
    assign o_idx     = r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_en) begin
            r_idx <= w_at_last ? '0 : r_idx + 1'b1;
        end
    end

endmodule

// File: rtl/filter_tap_accumulator.sv
// filter_tap_accumulator: sums TAPS signed tap products per window and hands
// the window sum downstream on a valid/ready output; checks tap ordering.
//   clk, reset          : clock, asynchronous active-low reset
//   in_valid/in_ready   : tap product input handshake
//   in_data, in_tap     : signed product and the sender's tap index
//   out_valid/out_ready : window result handshake
//   out_data            : window sum (truncated, or clamped with ACC_SAT_EN)
//   exp_tap             : index of the next expected tap
//   tap_err             : sticky, set when in_tap differs from exp_tap
//   ovf                 : sticky, set when the result was clamped
//   win_cnt             : completed (handed-off) windows, wraps
//   dbg_state           : current FSM state
// Build option: define ACC_SAT_EN to saturate out_data to the signed OUT_W
// range; otherwise out_data is the low OUT_W bits and ovf is always 0.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds with its data until that transfer.
module filter_tap_accumulator
    import filter_pkg::*;
#(
    parameter int TAPS   = TAPS_DEFAULT,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]         in_tap,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic [IDX_W-1:0]         exp_tap,
    output logic                     tap_err,
    output logic                     ovf,
    output logic [15:0]              win_cnt,
    output state_t                   dbg_state
);

    state_t                    r_state;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_out_valid;
    logic signed [OUT_W-1:0]   r_out_data;
    logic                      r_tap_err;
    logic                      r_ovf;
    logic [15:0]               r_win_cnt;

    logic                      w_accept;
    logic                      w_last_tap;
    logic [IDX_W-1:0]          w_exp_tap;
    logic signed [ACC_W-1:0]   w_data_ext;
    logic signed [ACC_W-1:0]   w_sum;
    logic [OUT_W-1:0]          w_result;
    logic                      w_clip;

    // in_ready depends on state only, so there is no out_ready -> in_ready path.
    assign in_ready = (r_state == ACCUM);
    assign w_accept = in_valid & in_ready;

    tap_index_counter #(
        .TAPS (TAPS),
        .W    (IDX_W)
    ) u_tap_index_counter (
        .clk    (clk),
        .rst_n  (reset),
        .i_en   (w_accept),
        .i_clr  (1'b0),
        .o_idx  (w_exp_tap),
        .o_wrap (w_last_tap)
    );

    assign w_data_ext = {{(ACC_W - DATA_W){in_data[DATA_W-1]}}, in_data};
    // Wraps silently in ACC_W bits.
    assign w_sum      = r_acc + w_data_ext;

`ifdef ACC_SAT_EN
    logic signed [63:0] w_sum_64;
    logic signed [63:0] w_clamped;

    assign w_sum_64  = {{(64 - ACC_W){w_sum[ACC_W-1]}}, w_sum};
    assign w_clamped = clamp_signed(w_sum_64, OUT_W);
    assign w_result  = w_clamped[OUT_W-1:0];
    assign w_clip    = (w_clamped != w_sum_64);
`else
    assign w_result  = w_sum[OUT_W-1:0];
    assign w_clip    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_tap_err   <= 1'b0;
            r_ovf       <= 1'b0;
            r_win_cnt   <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        // A misordered tap is flagged but still summed.
                        if (in_tap != w_exp_tap) begin
                            r_tap_err <= 1'b1;
                        end
                        if (w_last_tap) begin
                            r_out_data  <= w_result;
                            r_out_valid <= 1'b1;
                            r_acc       <= '0;
                            r_state     <= HOLD;
                            if (w_clip) begin
                                r_ovf <= 1'b1;
                            end
                        end else begin
                            r_acc <= w_sum;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_win_cnt   <= r_win_cnt + 16'd1;
                        r_state     <= ACCUM;
                    end
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign exp_tap   = w_exp_tap;
    assign tap_err   = r_tap_err;
    assign ovf       = r_ovf;
    assign win_cnt   = r_win_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_filter_tap_accumulator.sv
// Bench for filter_tap_accumulator (TAPS=25, DATA_W=16, ACC_W=40, OUT_W=16).
// Expected window results come from a longint model and sit in a queue until
// the DUT hands the result off. Expectations follow ACC_SAT_EN when defined.
module tb_filter_tap_accumulator;
    import filter_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [4:0]  in_tap;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [4:0]  exp_tap;
    logic        tap_err;
    logic        ovf;
    logic [15:0] win_cnt;
    state_t      dbg_state;

    logic [15:0] exp_q[$];
    logic        exp_ovf;
    int          errors;
    int          checks;

    filter_tap_accumulator #(
        .TAPS   (25),
        .DATA_W (16),
        .ACC_W  (40),
        .OUT_W  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tap    (in_tap),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .exp_tap   (exp_tap),
        .tap_err   (tap_err),
        .ovf       (ovf),
        .win_cnt   (win_cnt),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input longint s);
`ifdef ACC_SAT_EN
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        return s[15:0];
    endfunction

    // Scoreboard: compare at each result handoff (sampled clear of both edges).
    always @(negedge clk) begin
        #1;
        if (out_valid && out_ready && reset) begin
            check("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                check("sb_out_data", {48'd0, out_data}, {48'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        exp_ovf  = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {48'd0, out_data}, 64'd0);
        check("rst_exp_tap", {59'd0, exp_tap}, 64'd0);
        check("rst_tap_err", {63'd0, tap_err}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        check("rst_win_cnt", {48'd0, win_cnt}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_tap(input logic [15:0] d, input logic [4:0] t);
        int guard;
        guard    = 0;
        in_data  = d;
        in_tap   = t;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("tap_accept_wait", {63'd0, guard < 200}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_window(input int val, input int bad_pos, input int gap_max);
        longint      s;
        logic [4:0]  t;
        int          gap;
        s = 0;
        for (int i = 0; i < 25; i++) begin
            t = (i == bad_pos) ? 5'd9 : 5'(i);
            s += val;
            if (i == 24) begin
                exp_q.push_back(model(s));
`ifdef ACC_SAT_EN
                if (s > 32767 || s < -32768) exp_ovf = 1'b1;
`endif
            end
            if (gap_max > 0) begin
                gap = $urandom_range(0, gap_max);
                repeat (gap) @(negedge clk);
            end
            send_tap(16'(val), t);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_tap    = '0;
        out_ready = 1'b0;
        exp_ovf   = 1'b0;
        repeat (2) @(negedge clk);

        // 1: 25 taps of +1, result one cycle after the last tap
        do_reset();
        out_ready = 1'b1;
        send_window(1, -1, 0);
        check("t1_out_valid", {63'd0, out_valid}, 64'd1);
        check("t1_out_data", {48'd0, out_data}, 64'd25);
        @(negedge clk);
        check("t1_win_cnt", {48'd0, win_cnt}, 64'd1);
        check("t1_tap_err", {63'd0, tap_err}, 64'd0);
        check("t1_out_valid_clr", {63'd0, out_valid}, 64'd0);
        check("t1_exp_tap", {59'd0, exp_tap}, 64'd0);

        // 2: back-pressure holds the result stable
        do_reset();
        out_ready = 1'b0;
        send_window(-1000, -1, 0);
        for (int c = 0; c < 10; c++) begin
            check("t2_hold_valid", {63'd0, out_valid}, 64'd1);
            check("t2_hold_data", {48'd0, out_data}, {48'd0, model(-25000)});
            check("t2_hold_in_ready", {63'd0, in_ready}, 64'd0);
            check("t2_hold_state", {63'd0, dbg_state == HOLD}, 64'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t2_win_cnt", {48'd0, win_cnt}, 64'd1);
        check("t2_out_valid_clr", {63'd0, out_valid}, 64'd0);
        check("t2_in_ready", {63'd0, in_ready}, 64'd1);
        in_data  = 16'd5;
        in_tap   = 5'd0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("t2_next_tap", {59'd0, exp_tap}, 64'd1);

        // 3: misordered tap 7 is flagged, sum unaffected, flag sticky
        do_reset();
        out_ready = 1'b1;
        send_window(3, 7, 0);
        check("t3_tap_err", {63'd0, tap_err}, 64'd1);
        send_window(3, -1, 0);
        @(negedge clk);
        check("t3_tap_err_sticky", {63'd0, tap_err}, 64'd1);
        check("t3_win_cnt", {48'd0, win_cnt}, 64'd2);

        // 4: sum exceeding the 16-bit output range
        do_reset();
        out_ready = 1'b1;
        send_window(32767, -1, 0);
        check("t4_out_data", {48'd0, out_data}, {48'd0, model(64'sd819175)});
        check("t4_ovf", {63'd0, ovf}, {63'd0, exp_ovf});
        @(negedge clk);

        // 5: idle mid-window freezes, reset discards the partial sum
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            send_tap(16'd2, 5'(i));
        end
        repeat (3) @(negedge clk);
        check("t5_idle_exp_tap", {59'd0, exp_tap}, 64'd13);
        do_reset();
        out_ready = 1'b1;
        send_window(2, -1, 0);
        check("t5_out_data", {48'd0, out_data}, 64'd50);
        @(negedge clk);
        check("t5_win_cnt", {48'd0, win_cnt}, 64'd1);

        // 6: random gaps in in_valid over three windows
        do_reset();
        out_ready = 1'b1;
        for (int k = 4; k <= 6; k++) begin
            send_window(k, -1, 2);
        end
        @(negedge clk);
        check("t6_win_cnt", {48'd0, win_cnt}, 64'd3);
        check("t6_sb_drained", {32'd0, 32'(exp_q.size())}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
